multicycle_adder: RTL and testbench

Parametrised sequential adder/subtractor for the MIPS datapath. It adds or subtracts two WIDTH-bit operands by rippling one SLICE-bit chunk per clock through a single slice adder, trading latency for area. A start/busy/done handshake drives it, and it returns carry-out and signed-overflow flags. It generalises the four-bit ripple adder to arbitrary width, adds subtraction and flags, and replaces the combinational ripple with a multi-cycle schedule.

---
 rtl/multicycle_adder_pkg.sv | 24 ++
 rtl/multicycle_adder_if.sv | 27 ++
 rtl/multicycle_adder_slice_adder.sv | 30 +++
 rtl/multicycle_adder.sv | 152 +++++++++++++++
 tb/tb_multicycle_adder.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_adder_pkg.sv
// Shared definitions for the multi-cycle adder: FSM state encoding and a
// ceiling-log2 helper used to size the slice index counter.
package multicycle_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Ceiling log2 with a floor of 1, so a single-slice adder still gets a
  // one-bit counter instead of a zero-width vector.
  function automatic int clog2_min1(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/multicycle_adder_if.sv
// Handshake and operand/result bus of the multi-cycle adder.
// The master drives requests and operands; the slave (the adder) returns
// status, result and flags.
interface multicycle_adder_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] in_1;
  logic [WIDTH-1:0] in_2;
  logic             c_in;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;

  modport master (
    output start, in_1, in_2, c_in, sub,
    input  busy, done, sum, c_out, overflow
  );

  modport slave (
    input  start, in_1, in_2, c_in, sub,
    output busy, done, sum, c_out, overflow
  );
endinterface

// File: rtl/multicycle_adder_slice_adder.sv
// SLICE-bit combinational ripple adder. Besides the carry out it exposes the
// carry into its own MSB so the top level can derive signed overflow from
// the most significant slice.
module slice_adder #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             c_in,
  output logic [SLICE-1:0] s,
  output logic             c_out,
  output logic             c_msb
);

  logic carry_s;

  // Ripple through the low bits, capture the carry entering the MSB, then finish the MSB
  always_comb begin
    carry_s = c_in;
    s       = '0;
    for (int i = 0; i < SLICE - 1; i++) begin
      s[i]    = a[i] ^ b[i] ^ carry_s;
      carry_s = (a[i] & b[i]) | (a[i] & carry_s) | (b[i] & carry_s);
    end
    c_msb          = carry_s;
    s[SLICE-1]     = a[SLICE-1] ^ b[SLICE-1] ^ carry_s;
    c_out          = (a[SLICE-1] & b[SLICE-1]) | (a[SLICE-1] & carry_s) | (b[SLICE-1] & carry_s);
  end

endmodule

// File: rtl/multicycle_adder.sv
// Sequential adder/subtractor: one SLICE-bit chunk is added per clock through
// a single slice adder, so a WIDTH-bit operation takes WIDTH/SLICE cycles.
// Operands are held in shift registers whose low slice feeds the adder; the
// carry between slices lives in a flop. Subtraction is A + ~B + 1.
module multicycle_adder
  import multicycle_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input logic               clk,
  input logic               rst,
  multicycle_adder_if.slave bus
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = clog2_min1(N);
  localparam int OW = clog2_min1(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  state_e           state_r;
  state_e           state_nx_s;
  logic             load_s;
  logic             step_s;
  logic             last_s;

  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry_r;
  logic [CW-1:0]    idx_r;
  logic [OW-1:0]    ofs_s;

  logic [WIDTH-1:0] sum_r;
  logic             c_out_r;
  logic             overflow_r;
  logic             busy_r;
  logic             done_r;

  logic [SLICE-1:0] slice_sum_s;
  logic             slice_cout_s;
  logic             slice_cmsb_s;

  slice_adder #(.SLICE(SLICE)) u_slice (
    .a     (a_r[SLICE-1:0]),
    .b     (b_r[SLICE-1:0]),
    .c_in  (carry_r),
    .s     (slice_sum_s),
    .c_out (slice_cout_s),
    .c_msb (slice_cmsb_s)
  );

  assign last_s = (idx_r == LAST_IDX);
  assign ofs_s  = OW'(idx_r) * OW'(SLICE);

  // Next-state and control decode: accept in IDLE/DONE, step every RUN cycle
  always_comb begin
    state_nx_s = state_r;
    load_s     = 1'b0;
    step_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          load_s     = 1'b1;
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        step_s = 1'b1;
        if (last_s) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (bus.start) begin
          load_s     = 1'b1;
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Operand shift registers, inter-slice carry and slice index
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      carry_r <= 1'b0;
      idx_r   <= '0;
    end else if (load_s) begin
      a_r     <= bus.in_1;
      b_r     <= bus.sub ? ~bus.in_2 : bus.in_2;
      carry_r <= bus.sub ? 1'b1 : bus.c_in;
      idx_r   <= '0;
    end else if (step_s) begin
      a_r     <= a_r >> SLICE;
      b_r     <= b_r >> SLICE;
      carry_r <= slice_cout_s;
      idx_r   <= last_s ? '0 : idx_r + CW'(1);
    end
  end

  // Result slice write-back; flags are latched only on the final slice
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_r      <= '0;
      c_out_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else if (step_s) begin
      sum_r[ofs_s +: SLICE] <= slice_sum_s;
      if (last_s) begin
        c_out_r    <= slice_cout_s;
        overflow_r <= slice_cmsb_s ^ slice_cout_s;
      end
    end
  end

  // Registered status outputs follow the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_nx_s == ST_RUN);
      done_r <= (state_nx_s == ST_DONE);
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.sum      = sum_r;
  assign bus.c_out    = c_out_r;
  assign bus.overflow = overflow_r;

endmodule

// File: tb/tb_multicycle_adder.sv
// Bench for multicycle_adder: a cycle-level reference model of the 32/4
// instance (plain wide arithmetic plus a remaining-cycles counter) checked on
// every cycle, directed vectors with literal expectations, randomized traffic,
// and directed checks of 4/4 and 8/1 instances.
module tb_multicycle_adder;

  localparam int N32 = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  multicycle_adder_if #(.WIDTH(32)) bus32 ();
  multicycle_adder_if #(.WIDTH(4))  bus4 ();
  multicycle_adder_if #(.WIDTH(8))  bus8 ();

  multicycle_adder #(.WIDTH(32), .SLICE(4)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));
  multicycle_adder #(.WIDTH(4),  .SLICE(4)) dut4  (.clk(clk), .rst(rst), .bus(bus4.slave));
  multicycle_adder #(.WIDTH(8),  .SLICE(1)) dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model of the 32-bit instance
  int          m_rem  = 0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [31:0] m_sum  = 32'd0;
  logic        m_cout = 1'b0;
  logic        m_ovf  = 1'b0;
  logic [31:0] p_sum  = 32'd0;
  logic        p_cout = 1'b0;
  logic        p_ovf  = 1'b0;

  always @(posedge clk) begin : model
    logic [31:0] bp;
    logic [32:0] full;
    if (rst) begin
      m_rem <= 0; m_busy <= 1'b0; m_done <= 1'b0;
      m_sum <= 32'd0; m_cout <= 1'b0; m_ovf <= 1'b0;
    end else if (m_rem > 0) begin
      m_rem  <= m_rem - 1;
      m_busy <= (m_rem > 1);
      m_done <= (m_rem == 1);
      if (m_rem == 1) begin
        m_sum <= p_sum; m_cout <= p_cout; m_ovf <= p_ovf;
      end
    end else if (bus32.start === 1'b1) begin
      bp   = bus32.sub ? ~bus32.in_2 : bus32.in_2;
      full = {1'b0, bus32.in_1} + {1'b0, bp} + 33'(bus32.sub ? 1'b1 : bus32.c_in);
      p_sum  <= full[31:0];
      p_cout <= full[32];
      p_ovf  <= (bus32.in_1[31] == bp[31]) && (full[31] != bus32.in_1[31]);
      m_rem  <= N32;
      m_busy <= 1'b1;
      m_done <= 1'b0;
    end else begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
    end
  end

  // Per-cycle comparison of the 32-bit instance against the model
  always @(negedge clk) begin
    chk("busy", 32'(bus32.busy), 32'(m_busy));
    chk("done", 32'(bus32.done), 32'(m_done));
    if (!m_busy) begin
      chk("sum", bus32.sum, m_sum);
      chk("c_out", 32'(bus32.c_out), 32'(m_cout));
      chk("overflow", 32'(bus32.overflow), 32'(m_ovf));
    end
  end

  // One 32-bit operation with literal expectations; optional ignored start at cycle poke
  task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic sb,
                      input int poke, input logic [31:0] xs, input logic xc, input logic xo,
                      input string nm);
    int lat;
    bus32.start = 1'b1; bus32.in_1 = a; bus32.in_2 = b; bus32.c_in = ci; bus32.sub = sb;
    @(negedge clk);
    bus32.start = 1'b0; bus32.in_1 = $urandom; bus32.in_2 = $urandom;
    bus32.c_in = 1'($urandom); bus32.sub = 1'($urandom);
    lat = 0;
    while (bus32.done !== 1'b1 && lat < 40) begin
      bus32.start = (lat == poke) ? 1'b1 : 1'b0;
      @(negedge clk);
      lat++;
    end
    bus32.start = 1'b0;
    chk({nm, "_latency"}, 32'(lat), 32'(N32));
    chk({nm, "_sum"}, bus32.sum, xs);
    chk({nm, "_c_out"}, 32'(bus32.c_out), 32'(xc));
    chk({nm, "_overflow"}, 32'(bus32.overflow), 32'(xo));
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic ci, input logic sb,
                     input logic [3:0] xs, input logic xc, input logic xo, input string nm);
    int lat;
    bus4.start = 1'b1; bus4.in_1 = a; bus4.in_2 = b; bus4.c_in = ci; bus4.sub = sb;
    @(negedge clk);
    bus4.start = 1'b0;
    lat = 0;
    while (bus4.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_latency"}, 32'(lat), 32'd1);
    chk({nm, "_sum"}, 32'(bus4.sum), 32'(xs));
    chk({nm, "_c_out"}, 32'(bus4.c_out), 32'(xc));
    chk({nm, "_overflow"}, 32'(bus4.overflow), 32'(xo));
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic sb,
                     input logic [7:0] xs, input logic xc, input logic xo, input string nm);
    int lat;
    bus8.start = 1'b1; bus8.in_1 = a; bus8.in_2 = b; bus8.c_in = ci; bus8.sub = sb;
    @(negedge clk);
    bus8.start = 1'b0;
    lat = 0;
    while (bus8.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_latency"}, 32'(lat), 32'd8);
    chk({nm, "_sum"}, 32'(bus8.sum), 32'(xs));
    chk({nm, "_c_out"}, 32'(bus8.c_out), 32'(xc));
    chk({nm, "_overflow"}, 32'(bus8.overflow), 32'(xo));
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = 32'h0000_0000;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'h8000_0000;
      3: v = 32'h7FFF_FFFF;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    bus32.start = 1'b0; bus32.in_1 = 32'd0; bus32.in_2 = 32'd0; bus32.c_in = 1'b0; bus32.sub = 1'b0;
    bus4.start = 1'b0;  bus4.in_1 = 4'd0;   bus4.in_2 = 4'd0;   bus4.c_in = 1'b0;  bus4.sub = 1'b0;
    bus8.start = 1'b0;  bus8.in_1 = 8'd0;   bus8.in_2 = 8'd0;   bus8.c_in = 1'b0;  bus8.sub = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", 32'(bus32.busy), 32'd0);
    chk("reset_done", 32'(bus32.done), 32'd0);
    chk("reset_sum", bus32.sum, 32'd0);
    chk("reset_flags", {30'd0, bus32.c_out, bus32.overflow}, 32'd0);

    // Directed vectors
    op32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, -1, 32'h0000_0000, 1'b1, 1'b0, "wrap");
    @(negedge clk);
    op32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, -1, 32'h8000_0000, 1'b0, 1'b1, "pos_ovf");
    op32(32'h0000_000F, 32'h0000_0000, 1'b1, 1'b0, -1, 32'h0000_0010, 1'b0, 1'b0, "cin_cross");
    @(negedge clk);
    op32(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, -1, 32'hFFFF_FFFE, 1'b0, 1'b0, "sub_borrow");
    op32(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, -1, 32'h7FFF_FFFF, 1'b1, 1'b1, "sub_ovf");
    @(negedge clk);
    op32(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 3, 32'h2345_6789, 1'b0, 1'b0, "ignored_start");
    op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, -1, 32'hFFFF_FFFF, 1'b1, 1'b0, "back_to_back");

    // Reset in the middle of an operation
    bus32.start = 1'b1; bus32.in_1 = 32'h0F0F_0F0F; bus32.in_2 = 32'h1111_1111; bus32.sub = 1'b0;
    @(negedge clk);
    bus32.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(bus32.busy), 32'd0);
    chk("abort_sum", bus32.sum, 32'd0);
    chk("abort_flags", {30'd0, bus32.c_out, bus32.overflow}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      chk("abort_no_done", 32'(bus32.done), 32'd0);
      @(negedge clk);
    end
    op32(32'h0000_0100, 32'h0000_0001, 1'b0, 1'b1, -1, 32'h0000_00FF, 1'b1, 1'b0, "after_abort");

    // Randomized traffic, including back-to-back requests and stray resets
    for (int cyc = 0; cyc < 1500; cyc++) begin
      bus32.start = ($urandom_range(0, 2) == 0);
      bus32.in_1  = pick_operand();
      bus32.in_2  = pick_operand();
      bus32.c_in  = 1'($urandom);
      bus32.sub   = 1'($urandom);
      rst         = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    bus32.start = 1'b0;
    repeat (12) @(negedge clk);

    // Single-slice and one-bit-slice instances
    op4(4'b1011, 4'b1011, 1'b0, 1'b0, 4'b0110, 1'b1, 1'b1, "w4_add");
    @(negedge clk);
    op4(4'b0011, 4'b0101, 1'b0, 1'b1, 4'b1110, 1'b0, 1'b0, "w4_sub");
    @(negedge clk);
    op8(8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, "w8_add");
    @(negedge clk);
    op8(8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, "w8_ovf");
    @(negedge clk);
    op8(8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, "w8_sub");
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
